rv32i_mem_port_arbiter: RTL and testbench

//  Shares one unified memory port between the core's instruction-fetch requester
//  and its load/store requester. Multi-cycle core: fetch and data accesses never

---
 rtl/rv32i_mem_port_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_rv32i_mem_port_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// rv32i_mem_port_arbiter
//
// Purpose:
//   Shares a single unified memory port between the instruction-fetch
//   requester and the load/store requester of a multi-cycle RV32I core.
//   Only one transaction is in flight at a time. Data accesses have fixed
//   priority, but fetch is forced through after IF_STARVE_LIMIT consecutive
//   contested data grants. A transaction that sees no memory response within
//   TIMEOUT_CYCLES is terminated with an error response.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   if_req_valid/addr/ready       fetch request handshake
//   if_rsp_valid/data/err         fetch response (1-cycle pulse)
//   dm_req_valid/we/be/addr/wdata load/store request
//   dm_req_ready                  load/store request accepted
//   dm_rsp_valid/rdata/err        load/store response (1-cycle pulse)
//   mem_req_valid/we/be/addr/wdata/ready   memory request channel
//   mem_rsp_valid/rdata           memory response channel
//   busy                          a transaction is in progress
// ----------------------------------------------------------------------------
module rv32i_mem_port_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES  = 255,
    parameter int IF_STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    if_req_valid,
    input  logic [ADDR_WIDTH-1:0]   if_req_addr,
    output logic                    if_req_ready,
    output logic                    if_rsp_valid,
    output logic [DATA_WIDTH-1:0]   if_rsp_data,
    output logic                    if_rsp_err,

    input  logic                    dm_req_valid,
    input  logic                    dm_req_we,
    input  logic [DATA_WIDTH/8-1:0] dm_req_be,
    input  logic [ADDR_WIDTH-1:0]   dm_req_addr,
    input  logic [DATA_WIDTH-1:0]   dm_req_wdata,
    output logic                    dm_req_ready,
    output logic                    dm_rsp_valid,
    output logic [DATA_WIDTH-1:0]   dm_rsp_rdata,
    output logic                    dm_rsp_err,

    output logic                    mem_req_valid,
    output logic                    mem_req_we,
    output logic [DATA_WIDTH/8-1:0] mem_req_be,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic [DATA_WIDTH-1:0]   mem_req_wdata,
    input  logic                    mem_req_ready,
    input  logic                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_rdata,

    output logic                    busy
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int TIMER_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int STARVE_W = $clog2(IF_STARVE_LIMIT + 1);

    // The timer holds the number of ISSUE/WAIT cycles already completed, so
    // the cycle that completes the limit is the one where it reads LIMIT-1.
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(IF_STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                 state;
    logic                   owner_dm;
    logic [TIMER_W-1:0]     timer;
    logic [STARVE_W-1:0]    starve_cnt;
    logic [DATA_WIDTH-1:0]  rdata_q;

    logic                   idle;
    logic                   if_forced;
    logic                   grant_dm;
    logic                   grant_if;
    logic                   timeout_hit;

    assign idle = (state == S_IDLE);
    assign busy = !idle;

    always_comb begin
        if_forced   = if_req_valid && (starve_cnt >= STARVE_MAX);
        grant_dm    = dm_req_valid && !if_forced;
        grant_if    = if_req_valid && !grant_dm;
        // A real response arriving in the final WAIT cycle beats the timeout.
        timeout_hit = (timer == TIMER_LAST) &&
                      ((state == S_ISSUE) || ((state == S_WAIT) && !mem_rsp_valid));
    end

    assign if_req_ready = idle && grant_if;
    assign dm_req_ready = idle && grant_dm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            owner_dm      <= 1'b0;
            timer         <= '0;
            starve_cnt    <= '0;
            rdata_q       <= '0;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_be    <= '0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            if_rsp_valid  <= 1'b0;
            if_rsp_data   <= '0;
            if_rsp_err    <= 1'b0;
            dm_rsp_valid  <= 1'b0;
            dm_rsp_rdata  <= '0;
            dm_rsp_err    <= 1'b0;
        end else begin
            // Response outputs are single-cycle pulses and read as zero otherwise.
            if_rsp_valid <= 1'b0;
            if_rsp_data  <= '0;
            if_rsp_err   <= 1'b0;
            dm_rsp_valid <= 1'b0;
            dm_rsp_rdata <= '0;
            dm_rsp_err   <= 1'b0;

            if (timeout_hit) begin
                mem_req_valid <= 1'b0;
                state         <= S_IDLE;
                if (owner_dm) begin
                    dm_rsp_valid <= 1'b1;
                    dm_rsp_err   <= 1'b1;
                end else begin
                    if_rsp_valid <= 1'b1;
                    if_rsp_err   <= 1'b1;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (grant_dm) begin
                            owner_dm      <= 1'b1;
                            mem_req_valid <= 1'b1;
                            mem_req_we    <= dm_req_we;
                            mem_req_be    <= dm_req_be;
                            mem_req_addr  <= dm_req_addr;
                            mem_req_wdata <= dm_req_wdata;
                            timer         <= '0;
                            state         <= S_ISSUE;
                            // Only grants that actually held off a fetch count.
                            if (!if_req_valid) begin
                                starve_cnt <= '0;
                            end else if (starve_cnt != STARVE_MAX) begin
                                starve_cnt <= starve_cnt + 1'b1;
                            end
                        end else if (grant_if) begin
                            owner_dm      <= 1'b0;
                            mem_req_valid <= 1'b1;
                            mem_req_we    <= 1'b0;
                            mem_req_be    <= '0;
                            mem_req_addr  <= if_req_addr;
                            mem_req_wdata <= '0;
                            timer         <= '0;
                            starve_cnt    <= '0;
                            state         <= S_ISSUE;
                        end
                    end

                    S_ISSUE: begin
                        timer <= timer + 1'b1;
                        if (mem_req_ready) begin
                            mem_req_valid <= 1'b0;
                            state         <= S_WAIT;
                        end
                    end

                    S_WAIT: begin
                        timer <= timer + 1'b1;
                        if (mem_rsp_valid) begin
                            // Stores complete with an ack only; their data reads 0.
                            rdata_q <= mem_req_we ? '0 : mem_rsp_rdata;
                            state   <= S_RESP;
                        end
                    end

                    S_RESP: begin
                        state <= S_IDLE;
                        if (owner_dm) begin
                            dm_rsp_valid <= 1'b1;
                            dm_rsp_rdata <= rdata_q;
                        end else begin
                            if_rsp_valid <= 1'b1;
                            if_rsp_data  <= rdata_q;
                        end
                    end

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rv32i_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rv32i_mem_port_arbiter
//
// Self-checking bench for rv32i_mem_port_arbiter (TIMEOUT_CYCLES=8,
// IF_STARVE_LIMIT=4). A table of transactions is applied one at a time with a
// bench-side memory whose ready/response delays come from the table; expected
// responses are queued on acceptance and compared when the DUT responds.
// Hand-written sequences cover reset, starvation and reset during WAIT.
// ----------------------------------------------------------------------------
module tb_rv32i_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        if_rsp_err;
    logic        dm_req_valid;
    logic        dm_req_we;
    logic [3:0]  dm_req_be;
    logic [31:0] dm_req_addr;
    logic [31:0] dm_req_wdata;
    logic        dm_req_ready;
    logic        dm_rsp_valid;
    logic [31:0] dm_rsp_rdata;
    logic        dm_rsp_err;
    logic        mem_req_valid;
    logic        mem_req_we;
    logic [3:0]  mem_req_be;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic        busy;

    rv32i_mem_port_arbiter #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8),
        .IF_STARVE_LIMIT(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_valid (if_req_valid),
        .if_req_addr  (if_req_addr),
        .if_req_ready (if_req_ready),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .if_rsp_err   (if_rsp_err),
        .dm_req_valid (dm_req_valid),
        .dm_req_we    (dm_req_we),
        .dm_req_be    (dm_req_be),
        .dm_req_addr  (dm_req_addr),
        .dm_req_wdata (dm_req_wdata),
        .dm_req_ready (dm_req_ready),
        .dm_rsp_valid (dm_rsp_valid),
        .dm_rsp_rdata (dm_rsp_rdata),
        .dm_rsp_err   (dm_rsp_err),
        .mem_req_valid(mem_req_valid),
        .mem_req_we   (mem_req_we),
        .mem_req_be   (mem_req_be),
        .mem_req_addr (mem_req_addr),
        .mem_req_wdata(mem_req_wdata),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_rdata(mem_rsp_rdata),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // mode: 0 = normal, 1 = memory never ready, 2 = ready but never responds
    typedef struct {
        bit          use_if;
        bit          use_dm;
        bit          we;
        logic [3:0]  be;
        logic [31:0] if_addr;
        logic [31:0] dm_addr;
        logic [31:0] wdata;
        logic [31:0] mdata;
        int          rd;
        int          rs;
        int          mode;
        bit          exp_dm;
        logic [31:0] exp_data;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        bit          dm;
        logic [31:0] data;
        bit          err;
        int          lat;
        int          acc;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   rsp_cnt = 0;
    exp_t sbq[$];
    exp_t mon_e;
    vec_t vecs[10];

    function automatic vec_t mk(bit use_if, bit use_dm, bit we, logic [3:0] be,
                                logic [31:0] if_addr, logic [31:0] dm_addr,
                                logic [31:0] wdata, logic [31:0] mdata,
                                int rd, int rs, int mode, bit exp_dm,
                                logic [31:0] exp_data, bit exp_err, int exp_lat);
        vec_t v;
        v.use_if = use_if;   v.use_dm = use_dm;   v.we = we;       v.be = be;
        v.if_addr = if_addr; v.dm_addr = dm_addr; v.wdata = wdata; v.mdata = mdata;
        v.rd = rd;           v.rs = rs;           v.mode = mode;
        v.exp_dm = exp_dm;   v.exp_data = exp_data;
        v.exp_err = exp_err; v.exp_lat = exp_lat;
        return v;
    endfunction

    function automatic logic [140:0] all_outs();
        return {if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
                dm_req_ready, dm_rsp_valid, dm_rsp_rdata, dm_rsp_err,
                mem_req_valid, mem_req_we, mem_req_be, mem_req_addr,
                mem_req_wdata, busy};
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no DUT event within the cycle budget", name);
    endtask

    function automatic bit accepted();
        return (if_req_valid && if_req_ready) || (dm_req_valid && dm_req_ready);
    endfunction

    task automatic wait_rsp(input string name, input int target);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (rsp_cnt >= target) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            bound_fail(name);
            sbq.delete();
        end
    endtask

    task automatic do_txn(input vec_t v, input int id);
        bit   got;
        int   n0;
        exp_t e;
        @(posedge clk); #1;
        if_req_valid = v.use_if;
        if_req_addr  = v.if_addr;
        dm_req_valid = v.use_dm;
        dm_req_we    = v.we;
        dm_req_be    = v.be;
        dm_req_addr  = v.dm_addr;
        dm_req_wdata = v.wdata;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (accepted()) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            bound_fail($sformatf("accept_%0d", id));
            if_req_valid = 1'b0;
            dm_req_valid = 1'b0;
            return;
        end
        chk($sformatf("ready_%0d", id), 160'({if_req_ready, dm_req_ready}),
            160'(v.exp_dm ? 2'b01 : 2'b10));
        n0 = rsp_cnt;
        e.dm = v.exp_dm; e.data = v.exp_data; e.err = v.exp_err;
        e.lat = v.exp_lat; e.acc = cyc;
        sbq.push_back(e);
        @(posedge clk); #1;
        if_req_valid = 1'b0;
        dm_req_valid = 1'b0;
        if (v.mode != 1) begin
            repeat (v.rd) begin @(posedge clk); #1; end
            mem_req_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("mem_req_%0d", id),
                160'({mem_req_valid, mem_req_we, mem_req_be, mem_req_addr, mem_req_wdata}),
                v.exp_dm ? 160'({1'b1, v.we, v.be, v.dm_addr, v.wdata})
                         : 160'({1'b1, 1'b0, 4'h0, v.if_addr, 32'h0}));
            @(posedge clk); #1;
            mem_req_ready = 1'b0;
            if (v.mode == 0) begin
                repeat (v.rs) begin @(posedge clk); #1; end
                mem_rsp_valid = 1'b1;
                mem_rsp_rdata = v.mdata;
                @(posedge clk); #1;
                mem_rsp_valid = 1'b0;
                mem_rsp_rdata = 32'h5a5a_5a5a;
            end
        end
        wait_rsp($sformatf("rsp_%0d", id), n0 + 1);
        @(negedge clk);
        chk($sformatf("idle_after_%0d", id), 160'({busy, mem_req_valid}), 160'(2'b00));
    endtask

    bit   starve_exp[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    initial begin
        bit   got;
        int   n0;
        exp_t e;

        rst = 1'b1;
        if_req_valid = 1'b0; if_req_addr = '0;
        dm_req_valid = 1'b0; dm_req_we = 1'b0; dm_req_be = '0;
        dm_req_addr = '0;    dm_req_wdata = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;

        // Response monitor: pops the scoreboard on every response pulse.
        fork
            forever begin
                @(negedge clk);
                if (!rst && (if_rsp_valid || dm_rsp_valid)) begin
                    rsp_cnt++;
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: got if=%0b dm=%0b, required no response",
                                 if_rsp_valid, dm_rsp_valid);
                    end else begin
                        mon_e = sbq.pop_front();
                        chk("rsp_owner", 160'({if_rsp_valid, dm_rsp_valid}),
                            160'(mon_e.dm ? 2'b01 : 2'b10));
                        chk("rsp_payload",
                            160'({if_rsp_data, if_rsp_err, dm_rsp_rdata, dm_rsp_err}),
                            mon_e.dm ? 160'({32'h0, 1'b0, mon_e.data, mon_e.err})
                                     : 160'({mon_e.data, mon_e.err, 32'h0, 1'b0}));
                        chk("rsp_latency", 160'(cyc - mon_e.acc - 1), 160'(mon_e.lat));
                    end
                end
            end
        join_none

        vecs[0] = mk(1, 0, 0, 4'h0, 32'h0400_0000, 32'h0,        32'h0,         32'h0000_0013, 0, 0, 0, 0, 32'h0000_0013, 0, 3);
        vecs[1] = mk(1, 1, 1, 4'h3, 32'h0400_0004, 32'h0000_0100, 32'hdead_beef, 32'h0000_ffff, 0, 0, 0, 1, 32'h0,         0, 3);
        vecs[2] = mk(0, 1, 0, 4'hf, 32'h0,         32'h0000_0200, 32'h0,         32'hcafe_f00d, 1, 2, 0, 1, 32'hcafe_f00d, 0, 6);
        vecs[3] = mk(1, 0, 0, 4'h0, 32'h0400_0008, 32'h0,        32'h0,         32'h00a0_0093, 2, 0, 0, 0, 32'h00a0_0093, 0, 5);
        vecs[4] = mk(1, 0, 0, 4'h0, 32'h0400_000c, 32'h0,        32'h0,         32'h0,         0, 0, 1, 0, 32'h0,         1, 8);
        vecs[5] = mk(0, 1, 0, 4'hf, 32'h0,         32'h0000_0300, 32'h0,         32'h0,         0, 0, 2, 1, 32'h0,         1, 8);
        vecs[6] = mk(0, 1, 0, 4'hf, 32'h0,         32'h0000_0304, 32'h0,         32'h1111_2222, 0, 4, 0, 1, 32'h1111_2222, 0, 7);
        vecs[7] = mk(0, 1, 0, 4'hf, 32'h0,         32'h0000_0308, 32'h0,         32'h1234_5678, 0, 6, 0, 1, 32'h1234_5678, 0, 9);
        vecs[8] = mk(0, 1, 1, 4'hc, 32'h0,         32'h0000_030c, 32'ha5a5_a5a5, 32'hffff_ffff, 3, 3, 0, 1, 32'h0,         0, 9);
        vecs[9] = mk(1, 0, 0, 4'h0, 32'h0400_0010, 32'h0,        32'h0,         32'h0000_0073, 0, 5, 0, 0, 32'h0000_0073, 0, 8);

        // Reset state
        repeat (3) @(negedge clk);
        chk("outs_in_reset", 160'(all_outs()), 160'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("outs_after_reset", 160'(all_outs()), 160'(0));

        // Table-driven transactions
        for (int i = 0; i < 10; i++) begin
            do_txn(vecs[i], i);
        end

        // Both requesters valid continuously: D,D,D,D,F,D,D,D,D,F
        @(posedge clk); #1;
        if_req_valid = 1'b1; if_req_addr = 32'h0500_0000;
        dm_req_valid = 1'b1; dm_req_we = 1'b0; dm_req_be = 4'hf;
        dm_req_addr = 32'h0000_0600; dm_req_wdata = '0;
        n0 = rsp_cnt;
        for (int g = 0; g < 10; g++) begin
            got = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (accepted()) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) begin
                bound_fail($sformatf("starve_accept_%0d", g));
                break;
            end
            chk($sformatf("starve_grant_%0d", g), 160'({if_req_ready, dm_req_ready}),
                160'(starve_exp[g] ? 2'b01 : 2'b10));
            e.dm = starve_exp[g]; e.data = 32'h1000 + 32'(g); e.err = 1'b0;
            e.lat = 3; e.acc = cyc;
            sbq.push_back(e);
            @(posedge clk); #1;
            mem_req_ready = 1'b1;
            @(posedge clk); #1;
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = 32'h1000 + 32'(g);
            @(posedge clk); #1;
            mem_rsp_valid = 1'b0;
            if (g == 9) begin
                if_req_valid = 1'b0;
                dm_req_valid = 1'b0;
            end
        end
        if_req_valid = 1'b0;
        dm_req_valid = 1'b0;
        wait_rsp("starve_rsp", n0 + 10);
        repeat (2) @(negedge clk);

        // Reset while waiting for memory: the late response must be dropped
        @(posedge clk); #1;
        if_req_valid = 1'b1; if_req_addr = 32'h0700_0000;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (accepted()) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) bound_fail("rstwait_accept");
        @(posedge clk); #1;
        if_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        @(negedge clk);
        chk("rstwait_busy_before", 160'({busy, mem_req_valid}), 160'(2'b10));
        #1;
        rst = 1'b1;
        n0 = rsp_cnt;
        @(negedge clk);
        chk("outs_in_midreset", 160'(all_outs()), 160'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hbad0_bad0;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("no_rsp_after_reset", 160'(rsp_cnt), 160'(n0));
        chk("outs_after_midreset", 160'(all_outs()), 160'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
